// File: rtl/count_sequencer.sv
// count_sequencer: triangle counter 0..L..0 repeated for N periods, with pause, abort and done/cyc_done pulses.
module count_sequencer #(
    parameter int WIDTH     = 8,
    parameter int CYC_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 pause,
    input  logic [WIDTH-1:0]     limit,
    input  logic [CYC_WIDTH-1:0] n_cycles,
    output logic [WIDTH-1:0]     count,
    output logic                 up_count,
    output logic                 busy,
    output logic [CYC_WIDTH-1:0] cyc_idx,
    output logic                 cyc_done,
    output logic                 done,
    output logic                 aborted
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
    state_t               state, state_nx;
    logic [WIDTH-1:0]     lim, lim_nx, count_nx;
    logic [CYC_WIDTH-1:0] n_reg, n_nx, cyc_nx;
    logic                 cyc_done_nx, done_nx, aborted_nx, period_end, last;
    assign up_count = (state == UP);
    assign busy     = (state != IDLE);
    // With L==1 the peak is also the last non-zero value, so the period ends straight from UP.
    assign period_end = (count == WIDTH'(1)) && (state == DOWN || (state == UP && lim == WIDTH'(1)));
    assign last       = (cyc_idx == n_reg - CYC_WIDTH'(1));
    always_comb begin
        state_nx    = state;
        lim_nx      = lim;
        n_nx        = n_reg;
        count_nx    = count;
        cyc_nx      = cyc_idx;
        cyc_done_nx = 1'b0;
        done_nx     = 1'b0;
        aborted_nx  = 1'b0;
        if (state == IDLE) begin
            if (start && !abort) begin
                if (limit != '0 && n_cycles != '0) begin
                    lim_nx   = limit;
                    n_nx     = n_cycles;
                    cyc_nx   = '0;
                    count_nx = '0;
                    state_nx = UP;
                end else begin
                    done_nx = 1'b1;
                end
            end
        end else if (abort) begin
            count_nx   = '0;
            cyc_nx     = '0;
            state_nx   = IDLE;
            aborted_nx = 1'b1;
        end else if (!pause) begin
            if (period_end) begin
                count_nx    = '0;
                cyc_nx      = cyc_idx + CYC_WIDTH'(1);
                cyc_done_nx = 1'b1;
                done_nx     = last;
                state_nx    = last ? IDLE : UP;
            end else if (state == UP) begin
                count_nx = (count == lim) ? count - WIDTH'(1) : count + WIDTH'(1);
                state_nx = (count == lim) ? DOWN : UP;
            end else begin
                count_nx = count - WIDTH'(1);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lim      <= '0;
            n_reg    <= '0;
            count    <= '0;
            cyc_idx  <= '0;
            cyc_done <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
        end else begin
            state    <= state_nx;
            lim      <= lim_nx;
            n_reg    <= n_nx;
            count    <= count_nx;
            cyc_idx  <= cyc_nx;
            cyc_done <= cyc_done_nx;
            done     <= done_nx;
            aborted  <= aborted_nx;
        end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: directed vectors with hand-computed expectations for count_sequencer.
module tb_count_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic [7:0] limit = '0;
    logic [3:0] n_cycles = '0;
    logic [7:0] count;
    logic [3:0] cyc_idx;
    logic       up_count, busy, cyc_done, done, aborted;
    int checks = 0, passes = 0;
    int s35 [12] = '{1, 2, 3, 2, 1, 0, 1, 2, 3, 2, 1, 0};
    int u35 [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    int s36 [11] = '{1, 2, 2, 2, 2, 3, 4, 3, 2, 1, 0};

    count_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pause(pause),
        .limit(limit), .n_cycles(n_cycles), .count(count), .up_count(up_count),
        .busy(busy), .cyc_idx(cyc_idx), .cyc_done(cyc_done), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int l, input int n);
        limit = 8'(l); n_cycles = 4'(n); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        chk("rst_count", count, 0); chk("rst_busy", busy, 0); chk("rst_up", up_count, 0);
        chk("rst_cyc", cyc_idx, 0); chk("rst_done", done, 0); chk("rst_abt", aborted, 0);
        chk("rst_cdone", cyc_done, 0);
        rst = 1'b0;

        go(3, 2);
        chk("r35_c0", count, 0); chk("r35_up0", up_count, 1); chk("r35_busy0", busy, 1);
        start = 1'b1; limit = 8'd7; n_cycles = 4'd1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("r35_count%0d", k), count, s35[k-1]);
            chk($sformatf("r35_up%0d", k), up_count, u35[k-1]);
            chk($sformatf("r35_cdone%0d", k), cyc_done, int'(k == 6 || k == 12));
            chk($sformatf("r35_done%0d", k), done, int'(k == 12));
            chk($sformatf("r35_busy%0d", k), busy, int'(k < 12));
        end
        start = 1'b0;
        chk("r35_cyc", cyc_idx, 2);

        go(4, 1);
        for (int k = 1; k <= 11; k++) begin
            pause = (k >= 3 && k <= 5);
            tick();
            chk($sformatf("r36_count%0d", k), count, s36[k-1]);
            chk($sformatf("r36_done%0d", k), done, int'(k == 11));
        end
        pause = 1'b0;
        chk("r36_busy", busy, 0);

        go(5, 3);
        repeat (16) tick();
        chk("r37_pre_count", count, 4); chk("r37_pre_up", up_count, 0); chk("r37_pre_cyc", cyc_idx, 1);
        abort = 1'b1; pause = 1'b1;
        tick();
        abort = 1'b0; pause = 1'b0;
        chk("r37_count", count, 0); chk("r37_busy", busy, 0); chk("r37_cyc", cyc_idx, 0);
        chk("r37_abt", aborted, 1); chk("r37_done", done, 0); chk("r37_cdone", cyc_done, 0);
        tick();
        chk("r37_abt_pulse", aborted, 0);

        abort = 1'b1; limit = 8'd3; n_cycles = 4'd1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("idle_abt_busy", busy, 0); chk("idle_abt_done", done, 0); chk("idle_abt_abt", aborted, 0);

        go(0, 3);
        chk("l0_done", done, 1); chk("l0_busy", busy, 0); chk("l0_count", count, 0);
        tick();
        chk("l0_done_pulse", done, 0);
        go(5, 0);
        chk("n0_done", done, 1); chk("n0_busy", busy, 0);

        go(1, 15);
        for (int k = 1; k <= 30; k++) begin
            tick();
            chk($sformatf("l1_count%0d", k), count, k % 2);
            chk($sformatf("l1_cdone%0d", k), cyc_done, int'(k % 2 == 0));
            chk($sformatf("l1_done%0d", k), done, int'(k == 30));
        end
        chk("l1_cyc", cyc_idx, 15); chk("l1_busy", busy, 0);

        pause = 1'b1;
        go(2, 1);
        chk("idle_pause_busy", busy, 1);
        pause = 1'b0;
        tick();
        chk("r39_pre_count", count, 1);
        rst = 1'b1; pause = 1'b1; start = 1'b1;
        tick();
        chk("r39_count", count, 0); chk("r39_busy", busy, 0); chk("r39_up", up_count, 0);
        chk("r39_cyc", cyc_idx, 0); chk("r39_done", done, 0); chk("r39_abt", aborted, 0);
        rst = 1'b0; pause = 1'b0;
        go(2, 1);
        chk("r39_restart", busy, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("r39_count%0d", k), count, (k == 2) ? 2 : k % 2);
            chk($sformatf("r39_done%0d", k), done, int'(k == 4));
        end

        go(2, 1);
        repeat (3) tick();
        chk("r40_pre_count", count, 1); chk("r40_pre_up", up_count, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("r40_abt", aborted, 1); chk("r40_done", done, 0); chk("r40_cdone", cyc_done, 0);
        chk("r40_count", count, 0); chk("r40_busy", busy, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the triangle count and limit.
REQ-002 SHALL have parameter CYC_WIDTH, default 4, bit width of the cycle-count request and progress outputs.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  run request; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  terminate run, return to IDLE.
REQ-007 SHALL have port pause  input  1  freeze run while high.
REQ-008 SHALL have port limit  input  WIDTH  triangle peak L; sampled on accepted start.
REQ-009 SHALL have port n_cycles  input  CYC_WIDTH  number of triangle periods N; sampled on accepted start.
REQ-010 SHALL have port count  output  WIDTH  current count value, registered.
REQ-011 SHALL have port up_count  output  1  1 = counting up, 0 = counting down or idle.
REQ-012 SHALL have port busy  output  1  high in states UP and DOWN.
REQ-013 SHALL have port cyc_idx  output  CYC_WIDTH  completed periods in current run.
REQ-014 SHALL have port cyc_done  output  1  one-cycle pulse at end of each period.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of final period.
REQ-016 SHALL have port aborted  output  1  one-cycle pulse when abort terminates an active run.

Function
REQ-017 SHALL implement states IDLE, UP, DOWN; all outputs registered.
REQ-018 IDLE: start=1, abort=0, L!=0, N!=0 SHALL latch L and N, clear cyc_idx, set count=0, enter UP.
REQ-019 IDLE: start with L==0 or N==0 SHALL leave state IDLE and count=0 and pulse done next cycle; busy stays 0.
REQ-020 UP, not paused: count!=L SHALL increment count by 1; count==L SHALL decrement count by 1 and enter DOWN.
REQ-021 DOWN, not paused: count>1 SHALL decrement count by 1.
REQ-022 DOWN, count==1 SHALL set count=0, increment cyc_idx, pulse cyc_done, and enter UP if cyc_idx+1<N, else IDLE with done pulsed in the same cycle.
REQ-023 Count sequence SHALL be 0,1..L,L-1..1,0 repeating; period 2L clocks; done visible exactly 2*L*N clocks after the start-accepting edge.
REQ-024 L==1 SHALL yield sequence 0,1,0 per period (period 2 clocks).
REQ-025 Count arithmetic SHALL never wrap; count stays within 0..L.
REQ-026 pause=1 in UP/DOWN SHALL hold count, state, cyc_idx; no cyc_done/done generated while paused.
REQ-027 pause in IDLE SHALL have no effect.
REQ-028 abort=1 in UP/DOWN SHALL set count=0, cyc_idx=0, enter IDLE, pulse aborted; no done/cyc_done that cycle.
REQ-029 abort SHALL take priority over pause and over period/run completion in the same cycle.
REQ-030 abort in IDLE SHALL be ignored, and start in the same cycle SHALL also be ignored.
REQ-031 start while busy SHALL be ignored; changes to limit/n_cycles while busy SHALL have no effect.
REQ-032 up_count SHALL equal 1 exactly when state is UP.

Reset
REQ-033 rst=1 at a rising edge SHALL force IDLE, count=0, cyc_idx=0, up_count=0, busy=0, cyc_done=0, done=0, aborted=0.
REQ-034 rst SHALL override start, abort, pause, including mid-run; no done/aborted pulse from a reset.

Verification
REQ-035 L=3, N=2, single start -> count 0,1,2,3,2,1,0,1,2,3,2,1,0; cyc_done at 6th and 12th edge; done with count=0 at 12th edge; busy then 0.
REQ-036 L=4, N=1, pause high for 3 clocks while count=2 going up -> count holds 2 for 3 clocks; done at edge 11.
REQ-037 L=5, N=3, abort at count=4 in DOWN of period 2 -> next cycle count=0, IDLE, cyc_idx=0, aborted=1, done=0.
REQ-038 start with L=0 -> done=1 for one cycle, busy=0; start with L=1, N=15 -> 30-clock run, cyc_idx reaches 15.
REQ-039 rst asserted mid-run with pause=1 and start=1 -> all outputs 0 next cycle; a new start after rst deasserts runs normally.
REQ-040 abort coincident with final count==1 in DOWN -> aborted=1, done=0, cyc_done=0.
